// File: rtl/wash_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the wash program run stage:
//   - phase index constants PH_WFILL..PH_DSPIN
//   - run-stage FSM state type
//   - bit positions/widths of the 26-bit packed phase-duration word
//     (MSB first: wfill[3] wash[4] wdrain[3] wspin[3] rfill[3] rinse[4]
//      rdrain[3] dspin[3]); the mode/timing setter packs with the same layout
//   - actuator decode function (phase -> valve/motor enables)
// -----------------------------------------------------------------------------
package wash_pkg;

  localparam int WORD_W = 26;
  // Widest possible program is 7*6 + 15*2 = 72 seconds.
  localparam int SUM_W  = 7;

  localparam logic [2:0] PH_WFILL  = 3'd0;
  localparam logic [2:0] PH_WASH   = 3'd1;
  localparam logic [2:0] PH_WDRAIN = 3'd2;
  localparam logic [2:0] PH_WSPIN  = 3'd3;
  localparam logic [2:0] PH_RFILL  = 3'd4;
  localparam logic [2:0] PH_RINSE  = 3'd5;
  localparam logic [2:0] PH_RDRAIN = 3'd6;
  localparam logic [2:0] PH_DSPIN  = 3'd7;

  localparam int WFILL_LSB  = 23;
  localparam int WFILL_W    = 3;
  localparam int WASH_LSB   = 19;
  localparam int WASH_W     = 4;
  localparam int WDRAIN_LSB = 16;
  localparam int WDRAIN_W   = 3;
  localparam int WSPIN_LSB  = 13;
  localparam int WSPIN_W    = 3;
  localparam int RFILL_LSB  = 10;
  localparam int RFILL_W    = 3;
  localparam int RINSE_LSB  = 6;
  localparam int RINSE_W    = 4;
  localparam int RDRAIN_LSB = 3;
  localparam int RDRAIN_W   = 3;
  localparam int DSPIN_LSB  = 0;
  localparam int DSPIN_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic inlet;
    logic wash;
    logic drain;
    logic spin;
  } act_t;

  // Spin phases keep the drain open so spun-out water can leave the drum.
  // Fill and drain are on disjoint phases, so they can never be open together.
  function automatic act_t act_decode(input logic [2:0] ph);
    act_t a;
    a = '0;
    case (ph)
      PH_WFILL, PH_RFILL:   a.inlet = 1'b1;
      PH_WASH, PH_RINSE:    a.wash  = 1'b1;
      PH_WDRAIN, PH_RDRAIN: a.drain = 1'b1;
      PH_WSPIN, PH_DSPIN: begin
        a.drain = 1'b1;
        a.spin  = 1'b1;
      end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/wash_phase_decode.sv
// -----------------------------------------------------------------------------
// wash_phase_decode
// Combinational unpack of the 26-bit phase-duration word into eight 4-bit
// durations (phase i occupies dur_flat[4*i +: 4]) and their zero-extended sum.
// Ports:
//   phase_times  in   packed durations, MSB first (layout in wash_pkg)
//   dur_flat     out  8 x 4-bit durations, phase 0 in the low nibble
//   total        out  sum of all eight durations (0..72)
// -----------------------------------------------------------------------------
module wash_phase_decode
  import wash_pkg::*;
(
  input  logic [WORD_W-1:0] phase_times,
  output logic [31:0]       dur_flat,
  output logic [SUM_W-1:0]  total
);

  always_comb begin
    dur_flat = '0;
    dur_flat[4*PH_WFILL  +: 4] = 4'(phase_times[WFILL_LSB  +: WFILL_W]);
    dur_flat[4*PH_WASH   +: 4] = 4'(phase_times[WASH_LSB   +: WASH_W]);
    dur_flat[4*PH_WDRAIN +: 4] = 4'(phase_times[WDRAIN_LSB +: WDRAIN_W]);
    dur_flat[4*PH_WSPIN  +: 4] = 4'(phase_times[WSPIN_LSB  +: WSPIN_W]);
    dur_flat[4*PH_RFILL  +: 4] = 4'(phase_times[RFILL_LSB  +: RFILL_W]);
    dur_flat[4*PH_RINSE  +: 4] = 4'(phase_times[RINSE_LSB  +: RINSE_W]);
    dur_flat[4*PH_RDRAIN +: 4] = 4'(phase_times[RDRAIN_LSB +: RDRAIN_W]);
    dur_flat[4*PH_DSPIN  +: 4] = 4'(phase_times[DSPIN_LSB  +: DSPIN_W]);
  end

  always_comb begin
    total = '0;
    for (int i = 0; i < 8; i++) begin
      total = total + SUM_W'(dur_flat[4*i +: 4]);
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// -----------------------------------------------------------------------------
// wash_sequencer
// Run-stage engine: latches the packed phase durations on start, counts each
// of the eight phases down on the 1 s tick and drives the actuators.
// Optional build macro: WASH_DOOR_INTERLOCK_EN (adds door_open / door_err).
// Ports:
//   cp, rst          clock, synchronous active-high reset
//   tick             1 s time-base pulse
//   start            latch phase_times and begin (ignored while busy)
//   abort            return to IDLE at once, no done pulse
//   pause            level, freeze the countdown with all actuators off
//   phase_times      26-bit packed durations
//   door_open        (interlock build) acts as pause in RUN
//   door_err         (interlock build) sticky door-opened-while-running flag
//   phase            current phase 0..7
//   phase_left       seconds left in current phase
//   total_left       seconds left in whole program
//   busy             high in RUN or HOLD
//   done             one-cycle pulse on completion
//   inlet_valve, wash_motor, drain_valve, spin_motor   actuator enables
//   state_dbg        current FSM state (state_e encoding)
// Control priority each cycle: rst > abort > start > pause > tick.
// -----------------------------------------------------------------------------
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_W  = 1,
  parameter int TOTAL_W = 7
) (
  input  logic               cp,
  input  logic               rst,
  input  logic [TICK_W-1:0]  tick,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [25:0]        phase_times,
`ifdef WASH_DOOR_INTERLOCK_EN
  input  logic               door_open,
  output logic               door_err,
`endif
  output logic [2:0]         phase,
  output logic [3:0]         phase_left,
  output logic [TOTAL_W-1:0] total_left,
  output logic               busy,
  output logic               done,
  output logic               inlet_valve,
  output logic               wash_motor,
  output logic               drain_valve,
  output logic               spin_motor,
  output logic [1:0]         state_dbg
);

  state_e             state_q, state_d;
  logic [2:0]         phase_q, phase_d;
  logic [3:0]         phase_left_q, phase_left_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [31:0]        dur_q, dur_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  act_t               act_q, act_d;

  logic [31:0]        new_dur;
  logic [SUM_W-1:0]   new_sum;
  logic [2:0]         next_ph;
  logic               hold_req;

  wash_phase_decode u_decode (
    .phase_times (phase_times),
    .dur_flat    (new_dur),
    .total       (new_sum)
  );

`ifdef WASH_DOOR_INTERLOCK_EN
  logic door_err_q, door_err_d;

  // An open door holds the program exactly like pause, and keeps holding
  // until both the door is shut and pause is released.
  assign hold_req = pause | door_open;

  always_comb begin
    door_err_d = door_err_q;
    if (abort) begin
      door_err_d = 1'b0;
    end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      door_err_d = 1'b0;
    end else if (state_q == ST_RUN && door_open) begin
      door_err_d = 1'b1;
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      door_err_q <= 1'b0;
    end else begin
      door_err_q <= door_err_d;
    end
  end

  assign door_err = door_err_q;
`else
  assign hold_req = pause;
`endif

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    phase_left_d = phase_left_q;
    total_d      = total_q;
    dur_d        = dur_q;
    done_d       = 1'b0;
    next_ph      = phase_q + 3'd1;

    if (abort) begin
      state_d      = ST_IDLE;
      phase_d      = PH_WFILL;
      phase_left_d = 4'd0;
      total_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d      = ST_RUN;
            dur_d        = new_dur;
            phase_d      = PH_WFILL;
            phase_left_d = new_dur[4*PH_WFILL +: 4];
            total_d      = TOTAL_W'(new_sum);
          end
        end
        ST_RUN: begin
          if (hold_req) begin
            state_d = ST_HOLD;
          end else if (phase_left_q == 4'd0) begin
            // Phase boundary: this cycle never consumes a tick, so a
            // zero-length phase is visible for exactly one cycle.
            if (phase_q == PH_DSPIN) begin
              state_d      = ST_DONE;
              done_d       = 1'b1;
              phase_left_d = 4'd0;
              total_d      = '0;
            end else begin
              phase_d      = next_ph;
              phase_left_d = dur_q[{next_ph, 2'b00} +: 4];
            end
          end else if (tick[0]) begin
            phase_left_d = phase_left_q - 4'd1;
            total_d      = total_q - TOTAL_W'(1);
          end
        end
        ST_HOLD: begin
          if (!hold_req) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from next-state values so they change in the
    // same cycle as the phase they belong to.
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    act_d  = (state_d == ST_RUN) ? act_decode(phase_d) : '0;
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_WFILL;
      phase_left_q <= 4'd0;
      total_q      <= '0;
      dur_q        <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      act_q        <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      phase_left_q <= phase_left_d;
      total_q      <= total_d;
      dur_q        <= dur_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      act_q        <= act_d;
    end
  end

  assign phase       = phase_q;
  assign phase_left  = phase_left_q;
  assign total_left  = total_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign inlet_valve = act_q.inlet;
  assign wash_motor  = act_q.wash;
  assign drain_valve = act_q.drain;
  assign spin_motor  = act_q.spin;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wash_sequencer
// Directed and randomized stimulus for wash_sequencer, checked every cycle
// against a phase-list reference model of the wash program.
// Optional build macro: WASH_DOOR_INTERLOCK_EN (adds the door interlock steps).
// -----------------------------------------------------------------------------
module tb_wash_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        cp;
  logic        rst;
  logic        tick;
  logic        start;
  logic        abort;
  logic        pause;
  logic [25:0] phase_times;
  logic [2:0]  phase;
  logic [3:0]  phase_left;
  logic [6:0]  total_left;
  logic        busy;
  logic        done;
  logic        inlet_valve;
  logic        wash_motor;
  logic        drain_valve;
  logic        spin_motor;
  logic [1:0]  state_dbg;
  bit          door_drv;
`ifdef WASH_DOOR_INTERLOCK_EN
  logic        door_open;
  logic        door_err;
  assign door_open = door_drv;
`endif

  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  wash_sequencer #(.TICK_W(1), .TOTAL_W(7)) dut (
    .cp          (cp),
    .rst         (rst),
    .tick        (tick),
    .start       (start),
    .abort       (abort),
    .pause       (pause),
    .phase_times (phase_times),
`ifdef WASH_DOOR_INTERLOCK_EN
    .door_open   (door_open),
    .door_err    (door_err),
`endif
    .phase       (phase),
    .phase_left  (phase_left),
    .total_left  (total_left),
    .busy        (busy),
    .done        (done),
    .inlet_valve (inlet_valve),
    .wash_motor  (wash_motor),
    .drain_valve (drain_valve),
    .spin_motor  (spin_motor),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // The program is a list of eight durations; the model tracks which entry
  // is running and how much of it is left. Program time left is recomputed
  // from the list each cycle rather than counted down.
  int m_mode;
  int m_dur[8];
  int m_phase;
  int m_left;
  bit m_done;
  bit m_err;
  bit m_phase_known;

  function automatic int field(input logic [25:0] w, input int idx);
    int wid[8];
    int pos;
    wid = '{3, 4, 3, 3, 3, 4, 3, 3};
    pos = 26;
    for (int j = 0; j <= idx; j++) pos -= wid[j];
    return int'((w >> pos) & ((26'd1 << wid[idx]) - 26'd1));
  endfunction

  function automatic logic [25:0] pack8(input int d0, input int d1, input int d2, input int d3,
                                        input int d4, input int d5, input int d6, input int d7);
    int d[8];
    int wid[8];
    logic [25:0] r;
    d   = '{d0, d1, d2, d3, d4, d5, d6, d7};
    wid = '{3, 4, 3, 3, 3, 4, 3, 3};
    r   = '0;
    for (int i = 0; i < 8; i++) r = (r << wid[i]) | 26'(d[i]);
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    foreach (m_dur[i]) m_dur[i] = 0;
    m_phase = 0;
    m_left = 0;
    m_done = 1'b0;
    m_err = 1'b0;
    m_phase_known = 1'b1;
  endtask

  task automatic model_step(input bit t, input bit s, input bit a, input bit p,
                            input logic [25:0] w, input bit door);
    bit hold_req;
    hold_req = p || door;
    m_done = 1'b0;
    if (a) begin
      m_mode = M_IDLE;
      m_left = 0;
      m_err = 1'b0;
      m_phase_known = 1'b0;
    end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
      if (s) begin
        for (int i = 0; i < 8; i++) m_dur[i] = field(w, i);
        m_phase = 0;
        m_left = m_dur[0];
        m_mode = M_RUN;
        m_err = 1'b0;
        m_phase_known = 1'b1;
      end
    end else if (m_mode == M_RUN) begin
      if (door) m_err = 1'b1;
      if (hold_req) m_mode = M_HOLD;
      else if (m_left == 0) begin
        if (m_phase == 7) begin
          m_mode = M_DONE;
          m_done = 1'b1;
        end else begin
          m_phase++;
          m_left = m_dur[m_phase];
        end
      end else if (t) m_left--;
    end else if (!hold_req) m_mode = M_RUN;
  endtask

  function automatic int model_total();
    int s;
    if (m_mode != M_RUN && m_mode != M_HOLD) return 0;
    s = m_left;
    for (int i = m_phase + 1; i < 8; i++) s += m_dur[i];
    return s;
  endfunction

  task automatic check_outputs();
    bit run;
    run = (m_mode == M_RUN);
    if (m_phase_known) chk("phase", phase, m_phase);
    chk("phase_left", phase_left, m_left);
    chk("total_left", total_left, model_total());
    chk("busy", busy, (m_mode == M_RUN || m_mode == M_HOLD));
    chk("done", done, m_done);
    chk("inlet_valve", inlet_valve, run && (m_phase == 0 || m_phase == 4));
    chk("wash_motor", wash_motor, run && (m_phase == 1 || m_phase == 5));
    chk("drain_valve", drain_valve, run && (m_phase == 2 || m_phase == 3 || m_phase == 6 || m_phase == 7));
    chk("spin_motor", spin_motor, run && (m_phase == 3 || m_phase == 7));
    chk("fill_drain_exclusive", inlet_valve && drain_valve, 0);
`ifdef WASH_DOOR_INTERLOCK_EN
    chk("door_err", door_err, m_err);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit t, input bit s, input bit a, input bit p, input logic [25:0] w);
    tick = t;
    start = s;
    abort = a;
    pause = p;
    phase_times = w;
    @(posedge cp);
    model_step(t, s, a, p, w, door_drv);
    #1;
    check_outputs();
  endtask

  // Start a program, tick every cycle and check each phase's visible length
  // (duration + 1 boundary cycle), the total and the completion time.
  task automatic run_ticks(input logic [25:0] w, input int exp_sum, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] e;
    logic [2:0] cur_ph;
    int seg_cnt;
    int n_cyc;
    int n_done;
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 3'(i), 4'(field(w, i))});
    cycle(1'b0, 1'b1, 1'b0, 1'b0, w);
    chk({tag, "_total_at_start"}, total_left, exp_sum);
    cur_ph = phase;
    seg_cnt = 1;
    n_cyc = 0;
    n_done = 0;
    while (m_mode != M_DONE && n_cyc < 200) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, w);
      n_cyc++;
      if (done) n_done++;
      if (busy && phase == cur_ph) seg_cnt++;
      else begin
        if (exp_q.size() == 0) chk({tag, "_extra_phase"}, phase, 8);
        else begin
          e = exp_q.pop_front();
          chk({tag, "_seg_phase"}, cur_ph, e[6:4]);
          chk({tag, "_seg_len"}, seg_cnt, e[3:0] + 1);
        end
        cur_ph = phase;
        seg_cnt = 1;
      end
    end
    chk({tag, "_run_cycles"}, n_cyc, exp_sum + 8);
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_phases_left"}, exp_q.size(), 0);
  endtask

  task automatic run_to_done(input int tick_pct, input int pause_pct, input string tag);
    int n;
    n = 0;
    while (m_mode != M_DONE && n < 3000) begin
      cycle($urandom_range(99) < tick_pct, $urandom_range(99) < 3, 1'b0,
            $urandom_range(99) < pause_pct, 26'($urandom()));
      n++;
    end
    chk({tag, "_in_budget"}, n < 3000, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [25:0] w_def;
    logic [25:0] w_rinse;
    logic [25:0] w_rand;
    int n;

    w_def   = pack8(3, 10, 4, 5, 3, 8, 4, 5);
    w_rinse = pack8(0, 0, 0, 0, 4, 8, 4, 5);

    rst = 1'b1;
    tick = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pause = 1'b0;
    phase_times = '0;
    door_drv = 1'b0;
    repeat (2) @(posedge cp);
    #1;
    model_reset();
    chk("reset_phase", phase, 0);
    check_outputs();
    rst = 1'b0;

    // Full default program, then rinse-only with zero-length leading phases.
    run_ticks(w_def, 42, "default");
    run_ticks(w_rinse, 21, "rinse_only");

    // Pause in wash with 6 s left.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, w_def);
    n = 0;
    while (!(m_mode == M_RUN && m_phase == 1 && m_left == 6) && n < 100) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, w_def);
      n++;
    end
    chk("pause_reach_in_budget", n < 100, 1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, w_def);
    chk("pause_left_frozen", phase_left, 6);
    chk("pause_actuators_off", {inlet_valve, wash_motor, drain_valve, spin_motor}, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, w_def);
    chk("resume_left", phase_left, 6);
    chk("resume_wash_motor", wash_motor, 1);
    run_to_done(100, 0, "after_pause");

    // Abort mid-rinse, then restart with a fresh word.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, w_def);
    n = 0;
    while (m_phase != 5 && n < 100) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, w_def);
      n++;
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, w_def);
    chk("abort_busy", busy, 0);
    chk("abort_total", total_left, 0);
    chk("abort_done", done, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, w_rinse);
    chk("restart_total", total_left, 21);
    run_to_done(70, 0, "after_abort");

    // start while running is ignored; start with abort goes idle.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, w_def);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0, w_def);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 26'h3FF_FFFF);
    chk("start_ignored_total", total_left, 37);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 26'h3FF_FFFF);
    chk("start_abort_busy", busy, 0);
    chk("start_abort_total", total_left, 0);

    // Randomized programs with random ticks, pauses and stray starts.
    for (int r = 0; r < 6; r++) begin
      w_rand = 26'($urandom()) & 26'($urandom() | $urandom());
      cycle(1'b0, 1'b1, 1'b0, 1'b0, w_rand);
      run_to_done(60, 10, "random");
    end

`ifdef WASH_DOOR_INTERLOCK_EN
    cycle(1'b0, 1'b1, 1'b0, 1'b0, w_def);
    n = 0;
    while (m_phase != 1 && n < 100) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, w_def);
      n++;
    end
    door_drv = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, w_def);
    chk("door_hold_wash_off", wash_motor, 0);
    chk("door_err_set", door_err, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, w_def);
    door_drv = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b1, w_def);
    chk("door_pause_still_held", wash_motor, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, w_def);
    chk("door_resumed", wash_motor, 1);
    run_to_done(100, 0, "door");
    chk("door_err_sticky", door_err, 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, w_def);
    chk("door_err_cleared", door_err, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, w_def);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
